rtc_time_counter: RTL

- Time-keeping core of the real-time clock. Sits directly upstream of the 4-digit 7-segment display driver.
- Divides clk_i down to a 1 Hz tick and keeps a 24-hour BCD count: hours, minutes and seconds.
- Presents HH:MM as four BCD digits that feed the display driver's hr/min digit inputs.
- Provides a set mode so the user can advance hours and minutes with push-buttons.

---
 rtl/rtc_time_counter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/rtc_time_counter.sv
// Real-time clock core: divides clk_i to a 1 Hz tick and keeps a 24-hour BCD
// HH:MM:SS count, with a set mode that advances hours/minutes from push-buttons.
//
//   mode     | meaning
//   ---------+-----------------------------------------------------------
//   MODE_RUN | time advances on each prescaler tick while run_en_i is high
//   MODE_SET | seconds held at 00, button edges advance minutes / hours
module rtc_time_counter #(
    parameter int TICK_DIV = 100000000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       run_en_i,
    input  logic       set_mode_i,
    input  logic       inc_hr_i,
    input  logic       inc_min_i,
    output logic [3:0] hr_left_o,
    output logic [3:0] hr_right_o,
    output logic [3:0] min_left_o,
    output logic [3:0] min_right_o,
    output logic [3:0] sec_left_o,
    output logic [3:0] sec_right_o,
    output logic       sec_tick_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    typedef enum logic {
        MODE_RUN = 1'b0,
        MODE_SET = 1'b1
    } mode_t;

    // The mode register is the second flop of the set_mode_i synchroniser.
    logic    set_s1;
    mode_t   mode;
    logic [2:0] hr_sync;
    logic [2:0] min_sync;
    logic    hr_edge;
    logic    min_edge;

    logic [PW-1:0] presc;
    logic [PW-1:0] presc_nxt;
    logic          tick;

    logic [3:0] hr_l, hr_r, min_l, min_r, sec_l, sec_r;
    logic [3:0] hr_l_n, hr_r_n, min_l_n, min_r_n, sec_l_n, sec_r_n;

    function automatic logic [7:0] inc_base60(input logic [3:0] tens, input logic [3:0] units);
        if (units != 4'd9)
            return {tens, units + 4'd1};
        else if (tens != 4'd5)
            return {tens + 4'd1, 4'd0};
        else
            return 8'h00;
    endfunction

    function automatic logic [7:0] inc_hour(input logic [3:0] tens, input logic [3:0] units);
        if (tens == 4'd2 && units == 4'd3)
            return 8'h00;
        else if (units == 4'd9)
            return {tens + 4'd1, 4'd0};
        else
            return {tens, units + 4'd1};
    endfunction

    assign hr_edge  = hr_sync[1] & ~hr_sync[2];
    assign min_edge = min_sync[1] & ~min_sync[2];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            set_s1     <= 1'b0;
            mode       <= MODE_RUN;
            hr_sync    <= '0;
            min_sync   <= '0;
            presc      <= '0;
            sec_tick_o <= 1'b0;
            hr_l       <= '0;
            hr_r       <= '0;
            min_l      <= '0;
            min_r      <= '0;
            sec_l      <= '0;
            sec_r      <= '0;
        end else begin
            set_s1     <= set_mode_i;
            mode       <= mode_t'(set_s1);
            hr_sync    <= {hr_sync[1:0], inc_hr_i};
            min_sync   <= {min_sync[1:0], inc_min_i};
            presc      <= presc_nxt;
            sec_tick_o <= tick;
            hr_l       <= hr_l_n;
            hr_r       <= hr_r_n;
            min_l      <= min_l_n;
            min_r      <= min_r_n;
            sec_l      <= sec_l_n;
            sec_r      <= sec_r_n;
        end
    end

    always_comb begin
        presc_nxt = '0;
        tick      = 1'b0;
        hr_l_n    = hr_l;
        hr_r_n    = hr_r;
        min_l_n   = min_l;
        min_r_n   = min_r;
        sec_l_n   = sec_l;
        sec_r_n   = sec_r;
        case (mode)
            MODE_RUN: begin
                if (run_en_i) begin
                    if (presc == PRESC_MAX) begin
                        tick = 1'b1;
                        {sec_l_n, sec_r_n} = inc_base60(sec_l, sec_r);
                        // Carries ripple within the same edge, so 23:59:59 -> 00:00:00 at once.
                        if ({sec_l, sec_r} == 8'h59) begin
                            {min_l_n, min_r_n} = inc_base60(min_l, min_r);
                            if ({min_l, min_r} == 8'h59)
                                {hr_l_n, hr_r_n} = inc_hour(hr_l, hr_r);
                        end
                    end else begin
                        presc_nxt = presc + PW'(1);
                    end
                end
            end
            MODE_SET: begin
                sec_l_n = 4'd0;
                sec_r_n = 4'd0;
                if (min_edge)
                    {min_l_n, min_r_n} = inc_base60(min_l, min_r);
                if (hr_edge)
                    {hr_l_n, hr_r_n} = inc_hour(hr_l, hr_r);
            end
            default: ;
        endcase
    end

    assign hr_left_o   = hr_l;
    assign hr_right_o  = hr_r;
    assign min_left_o  = min_l;
    assign min_right_o = min_r;
    assign sec_left_o  = sec_l;
    assign sec_right_o = sec_r;

endmodule
